// File: rtl/pic_row_if.sv
// Handshake and ROM bus between pic_row_reader (master), the picture ROM and the LCD pixel consumer.
interface pic_row_if #(
   parameter int AW    = 9,
   parameter int PIX_W = 4,
   parameter int ROW_W = 3200
);
   logic             start;
   logic             busy;
   logic [AW-1:0]    rom_addr;
   logic [ROW_W-1:0] rom_q;
   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_sof;
   logic             pix_eol;
   logic             pix_eof;

   modport master (
      input  start, rom_q, pix_ready,
      output busy, rom_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );

   modport slave (
      output start, rom_q, pix_ready,
      input  busy, rom_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
   );
endinterface

// File: rtl/pic_row_reader.sv
// Walks picture ROM rows 0..ROWS-1 and serializes each packed row MSB-first into a pixel stream.
// Optional macro PIC_ROW_PREFETCH_EN buffers the next row so consecutive rows stream without a gap.
module pic_row_reader #(
   parameter int ROWS    = 10,
   parameter int ROW_PIX = 800,
   parameter int PIX_W   = 4,
   parameter int AW      = 9
) (
   input logic       clk,
   input logic       rst,
   pic_row_if.master bus
);
   localparam int ROW_W = ROW_PIX * PIX_W;
   localparam int CW    = $clog2(ROW_PIX);
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(ROW_PIX - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SHIFT = 2'd2} state_t;

`ifdef PIC_ROW_PREFETCH_EN
   localparam state_t ROW_NEXT = SHIFT;
`else
   localparam state_t ROW_NEXT = FETCH;
`endif

   state_t           state_r, state_s;
   logic [AW-1:0]    row_r, addr_r;
   logic [CW-1:0]    col_r;
   logic [ROW_W-1:0] shift_r;
   logic             xfer_s, last_col_s, last_row_s, row_end_s;
   logic             busy_s, valid_s, sof_s, eol_s, eof_s;
   logic [PIX_W-1:0] data_s;
`ifdef PIC_ROW_PREFETCH_EN
   logic [ROW_W-1:0] next_buf_r;
   logic             next_vld_r, next_pend_r;
`endif

   // Frame position decode shared by FSM and datapath
   always_comb begin
      last_col_s = (col_r == LAST_COL);
      last_row_s = (row_r == LAST_ROW);
      xfer_s     = (state_r == SHIFT) && bus.pix_ready;
      row_end_s  = xfer_s && last_col_s;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Next-state decode and stream outputs (decoded from registers only)
   always_comb begin
      state_s = state_r;
      busy_s  = 1'b0;
      valid_s = 1'b0;
      data_s  = {PIX_W{1'b0}};
      sof_s   = 1'b0;
      eol_s   = 1'b0;
      eof_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) state_s = FETCH;
            else           state_s = IDLE;
         end
         FETCH: begin
            busy_s  = 1'b1;
            state_s = SHIFT;
         end
         SHIFT: begin
            busy_s  = 1'b1;
            valid_s = 1'b1;
            data_s  = shift_r[ROW_W-1 -: PIX_W];
            sof_s   = (row_r == {AW{1'b0}}) && (col_r == {CW{1'b0}});
            eol_s   = last_col_s;
            eof_s   = last_col_s && last_row_s;
            if (row_end_s && last_row_s) state_s = IDLE;
            else if (row_end_s)          state_s = ROW_NEXT;
            else                         state_s = SHIFT;
         end
         default: state_s = IDLE;
      endcase
   end

   // Row/column counters, ROM address and pixel shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_r   <= {AW{1'b0}};
         col_r   <= {CW{1'b0}};
         addr_r  <= {AW{1'b0}};
         shift_r <= {ROW_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  row_r  <= {AW{1'b0}};
                  col_r  <= {CW{1'b0}};
                  addr_r <= {AW{1'b0}};
               end
            end
            FETCH: begin
               shift_r <= bus.rom_q;
`ifdef PIC_ROW_PREFETCH_EN
               if (!last_row_s) addr_r <= row_r + AW'(1);
`endif
            end
            SHIFT: begin
               if (xfer_s) begin
                  shift_r <= {shift_r[ROW_W-PIX_W-1:0], {PIX_W{1'b0}}};
                  col_r   <= col_r + CW'(1);
                  if (last_col_s) begin
                     col_r <= {CW{1'b0}};
                     if (last_row_s) begin
                        row_r  <= {AW{1'b0}};
                        addr_r <= {AW{1'b0}};
                     end else begin
                        row_r <= row_r + AW'(1);
`ifdef PIC_ROW_PREFETCH_EN
                        // Next row was buffered earlier; point the ROM at the one after it
                        shift_r <= next_vld_r ? next_buf_r : bus.rom_q;
                        if ((row_r + AW'(1)) != LAST_ROW) addr_r <= row_r + AW'(2);
`else
                        addr_r <= row_r + AW'(1);
`endif
                     end
                  end
               end
            end
            default: shift_r <= shift_r;
         endcase
      end
   end

`ifdef PIC_ROW_PREFETCH_EN
   // Next-row buffer: capture rom_q one cycle after the prefetch address is issued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_buf_r  <= {ROW_W{1'b0}};
         next_vld_r  <= 1'b0;
         next_pend_r <= 1'b0;
      end else if (state_r == FETCH) begin
         next_vld_r  <= 1'b0;
         next_pend_r <= !last_row_s;
      end else if (next_pend_r) begin
         next_buf_r  <= bus.rom_q;
         next_vld_r  <= 1'b1;
         next_pend_r <= 1'b0;
      end else if (row_end_s) begin
         next_vld_r  <= 1'b0;
         next_pend_r <= !last_row_s && ((row_r + AW'(1)) != LAST_ROW);
      end else begin
         next_pend_r <= next_pend_r;
      end
   end
`endif

   assign bus.busy      = busy_s;
   assign bus.rom_addr  = addr_r;
   assign bus.pix_data  = data_s;
   assign bus.pix_valid = valid_s;
   assign bus.pix_sof   = sof_s;
   assign bus.pix_eol   = eol_s;
   assign bus.pix_eof   = eof_s;
endmodule

// File: tb/tb_pic_row_reader.sv
// Self-checking bench for pic_row_reader: vector table, frame scoreboard and corner-case sequences.
module tb_pic_row_reader;
   localparam int ROWS = 3, ROW_PIX = 4, PIX_W = 4, AW = 9, ROW_W = 16;
`ifdef PIC_ROW_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   typedef struct {
      logic        start;
      logic        ready;
      logic [17:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rom_mem [0:2];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [6:0]  cap_q[$];
   logic [6:0]  exp_q[$];
   vec_t        vecs[$];

   pic_row_if #(.AW(AW), .PIX_W(PIX_W), .ROW_W(ROW_W)) bus();

   pic_row_reader #(.ROWS(ROWS), .ROW_PIX(ROW_PIX), .PIX_W(PIX_W), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (bus.rom_addr < 9'd3) bus.rom_q = rom_mem[bus.rom_addr[1:0]];
      else                     bus.rom_q = 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] nib(int r, int c);
      logic [15:0] w;
      w = rom_mem[r] >> (PIX_W * (ROW_PIX - 1 - c));
      return w[3:0];
   endfunction

   function automatic logic [17:0] ov(logic b, logic [8:0] a, logic v, logic [3:0] d,
                                      logic s, logic e, logic f);
      return {b, a, v, d, s, e, f};
   endfunction

   function automatic logic [17:0] obs();
      return ov(bus.busy, bus.rom_addr, bus.pix_valid, bus.pix_data,
                bus.pix_sof, bus.pix_eol, bus.pix_eof);
   endfunction

   task automatic add_vec(input logic s, input logic r, input logic [17:0] e);
      vec_t v;
      v.start = s;
      v.ready = r;
      v.exp   = e;
      vecs.push_back(v);
   endtask

   // reference stream: every pixel of the frame in order with its markers
   task automatic build_model();
      exp_q.delete();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < ROW_PIX; c++)
            exp_q.push_back({nib(r, c), 1'(r == 0 && c == 0), 1'(c == ROW_PIX - 1),
                             1'(c == ROW_PIX - 1 && r == ROWS - 1)});
   endtask

   task automatic cmp_stream(input string tag);
      chk($sformatf("%s count", tag), 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         chk($sformatf("%s px%0d", tag, i), {25'h0, cap_q[i]}, {25'h0, exp_q[i]});
   endtask

   // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random; inject_at: start pulse while showing that pixel index
   task automatic run_frame(input int rmode, input int inject_at,
                            output int fv, output int lx, output int dc, output int gaps);
      int          cyc;
      bit          seen, done, hold;
      logic [17:0] o, prev;
      cap_q.delete();
      fv = -1; lx = -1; dc = -1; gaps = 0;
      seen = 1'b0; done = 1'b0; hold = 1'b0; cyc = 0; prev = 18'h0;
      while (!done && cyc < 400) begin
         o = obs();
         if (rmode == 1)      bus.pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         else if (rmode == 2) bus.pix_ready = 1'($urandom_range(0, 1));
         else                 bus.pix_ready = 1'b1;
         bus.start = (cyc == 0) || (inject_at >= 0 && o[7] && cap_q.size() == inject_at);
         if (hold) chk($sformatf("hold c%0d", cyc), {24'h0, o[7:0]}, {24'h0, prev[7:0]});
         if (cyc == 1) chk("fetch cycle", {14'h0, o}, {14'h0, ov(1'b1, 9'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0)});
         if (o[7]) begin
            if (fv < 0) fv = cyc;
         end else if (fv >= 0 && o[17]) begin
            gaps++;
         end
         if (o[7] && bus.pix_ready) begin
            cap_q.push_back(o[6:0]);
            lx = cyc;
         end
         hold = o[7] && !bus.pix_ready;
         prev = o;
         if (o[17]) seen = 1'b1;
         if (seen && !o[17]) begin
            done = 1'b1;
            dc   = cyc;
         end else begin
            step();
            cyc++;
         end
      end
      bus.start = 1'b0;
      if (!done) chk("frame timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int fv, lx, dc, gaps, k;
      rom_mem[0] = 16'h1234;
      rom_mem[1] = 16'h5678;
      rom_mem[2] = 16'h9ABC;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pix_ready = 1'b0;
      #2;
      chk("reset state", {14'h0, obs()}, 32'd0);
      step();
      step();
      rst = 1'b0;
      chk("idle after reset", {14'h0, obs()}, 32'd0);

      // cycle-by-cycle table for a basic frame with pix_ready high
      add_vec(1'b1, 1'b1, ov(1'b0, 9'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
      for (int r = 0; r < ROWS; r++) begin
         if (r == 0 || !PF) add_vec(1'b0, 1'b1, ov(1'b1, 9'(r), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
         for (int c = 0; c < ROW_PIX; c++)
            add_vec(1'b0, 1'b1, ov(1'b1, PF ? 9'((r < ROWS - 1) ? r + 1 : r) : 9'(r), 1'b1, nib(r, c),
                                   1'(r == 0 && c == 0), 1'(c == ROW_PIX - 1),
                                   1'(c == ROW_PIX - 1 && r == ROWS - 1)));
      end
      add_vec(1'b0, 1'b1, ov(1'b0, 9'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < vecs.size(); i++) begin
         bus.start = vecs[i].start;
         bus.pix_ready = vecs[i].ready;
         chk($sformatf("vec%0d", i), {14'h0, obs()}, {14'h0, vecs[i].exp});
         step();
      end
      bus.start = 1'b0;

      build_model();
      run_frame(0, -1, fv, lx, dc, gaps);
      cmp_stream("basic");
      chk("first valid latency", 32'(fv), 32'd2);
      chk("row gaps", 32'(gaps), PF ? 32'd0 : 32'd2);
      chk("first to last span", 32'(lx - fv), PF ? 32'd11 : 32'd13);
      chk("busy low after eof", 32'(dc), 32'(lx + 1));

      run_frame(1, -1, fv, lx, dc, gaps);
      cmp_stream("backpressure");

      run_frame(0, 5, fv, lx, dc, gaps);
      cmp_stream("start while busy");
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("no restart %0d", i), {30'h0, bus.busy, bus.pix_valid}, 32'd0);
      end

      // abort with pixel 6 pending
      bus.start = 1'b1;
      bus.pix_ready = 1'b1;
      cap_q.delete();
      k = 0;
      while (k < 50 && !(bus.pix_valid && cap_q.size() == 5)) begin
         if (bus.pix_valid && bus.pix_ready) cap_q.push_back(obs() & 18'h7F);
         step();
         bus.start = 1'b0;
         k++;
      end
      chk("reach pixel 6", 32'(k < 50), 32'd1);
      bus.pix_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset mid-row", {14'h0, obs()}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("idle after abort", {14'h0, obs()}, 32'd0);
      run_frame(0, -1, fv, lx, dc, gaps);
      cmp_stream("after reset");

      for (int n = 0; n < 4; n++) begin
         for (int r = 0; r < ROWS; r++) rom_mem[r] = 16'($urandom);
         build_model();
         run_frame(2, -1, fv, lx, dc, gaps);
         cmp_stream($sformatf("random%0d", n));
      end

      rom_mem[0] = 16'h1234;
      rom_mem[1] = 16'h5678;
      rom_mem[2] = 16'h9ABC;
      build_model();
      run_frame(0, -1, fv, lx, dc, gaps);
      cmp_stream("b2b first");
      run_frame(0, -1, fv, lx, dc, gaps);
      cmp_stream("b2b second");
      chk("b2b first valid", 32'(fv), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
